// File: rtl/gray_pkg.sv
// Shared types and the Gray-to-binary helper used by both ends of the count link.
package gray_pkg;

    typedef enum logic [1:0] {IDLE, TRACK, FAULT} gray_rx_state_t;

    localparam int G2B_MAXW = 32;

    // Width-generic by zero extension: leading zero Gray bits decode to zero binary bits.
    function automatic logic [G2B_MAXW-1:0] gray2bin(input logic [G2B_MAXW-1:0] g);
        logic [G2B_MAXW-1:0] b;
        b[G2B_MAXW-1] = g[G2B_MAXW-1];
        for (int i = G2B_MAXW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_rx_if.sv
// Gray count link: sampled Gray bus in, decoded count and integrity status out.
interface gray_rx_if #(
    parameter int WIDTH = 3,
    parameter int ERRW  = 6
);
    logic [WIDTH-1:0] gray_in;
    logic             valid_in;
    logic [WIDTH-1:0] bin_out;
    logic             bin_valid;
    logic             dir;
    logic             step_err;
    logic [ERRW-1:0]  err_count;
    logic             locked;

    modport master (
        output gray_in, valid_in,
        input  bin_out, bin_valid, dir, step_err, err_count, locked
    );

    modport slave (
        input  gray_in, valid_in,
        output bin_out, bin_valid, dir, step_err, err_count, locked
    );
endinterface

// File: rtl/gray2bin_comb.sv
// Purely combinational Gray-to-binary decoder for a WIDTH-bit bus.
module gray2bin_comb
    import gray_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);
    assign bin_o = WIDTH'(gray2bin(G2B_MAXW'(gray_i)));
endmodule

// File: rtl/gray_rx.sv
// Gray count receiver: decodes samples, classifies each step as hold/up/down/illegal,
// and keeps direction, saturating error count and lock status.
module gray_rx
    import gray_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int ERRW   = 6,
    parameter int RELOCK = 2
) (
    input  logic      clk,
    input  logic      reset,
    gray_rx_if.slave  bus
);
    localparam logic [3:0] RELOCK_C = 4'(RELOCK);

    gray_rx_state_t   state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic             bin_vld_q, bin_vld_d;
    logic             dir_q, dir_d;
    logic             step_err_q, step_err_d;
    logic [ERRW-1:0]  err_cnt_q, err_cnt_d;
    logic             locked_q, locked_d;
    logic [3:0]       rel_cnt_q, rel_cnt_d;

    logic [WIDTH-1:0] bin_new;
    logic [WIDTH-1:0] diff;
    logic             is_hold, is_up, is_down;

    function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
        return (&v) ? v : v + ERRW'(1);
    endfunction

    gray2bin_comb #(.WIDTH(WIDTH)) u_dec (
        .gray_i (bus.gray_in),
        .bin_o  (bin_new)
    );

    assign diff    = bin_new - bin_q;
    assign is_hold = (diff == '0);
    assign is_up   = (diff == WIDTH'(1));
    assign is_down = (diff == '1);

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bin_vld_d  = 1'b0;
        dir_d      = dir_q;
        step_err_d = 1'b0;
        err_cnt_d  = err_cnt_q;
        rel_cnt_d  = rel_cnt_q;
        // Lock lags the state by one register, so it follows entry/exit one cycle late.
        locked_d   = (state_q == TRACK);

        if (bus.valid_in) begin
            unique case (state_q)
                IDLE: begin
                    bin_d     = bin_new;
                    bin_vld_d = 1'b1;
                    state_d   = TRACK;
                end
                TRACK: begin
                    if (is_up || is_down) begin
                        bin_d     = bin_new;
                        bin_vld_d = 1'b1;
                        dir_d     = is_up;
                    end else if (!is_hold) begin
                        bin_d      = bin_new;
                        bin_vld_d  = 1'b1;
                        step_err_d = 1'b1;
                        err_cnt_d  = sat_inc(err_cnt_q);
                        rel_cnt_d  = '0;
                        state_d    = FAULT;
                    end
                end
                FAULT: begin
                    if (is_up || is_down) begin
                        bin_d     = bin_new;
                        bin_vld_d = 1'b1;
                        dir_d     = is_up;
                        if (rel_cnt_q + 4'd1 >= RELOCK_C) begin
                            rel_cnt_d = '0;
                            state_d   = TRACK;
                        end else begin
                            rel_cnt_d = rel_cnt_q + 4'd1;
                        end
                    end else if (!is_hold) begin
                        bin_d      = bin_new;
                        bin_vld_d  = 1'b1;
                        step_err_d = 1'b1;
                        err_cnt_d  = sat_inc(err_cnt_q);
                        rel_cnt_d  = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            bin_vld_q  <= 1'b0;
            dir_q      <= 1'b1;
            step_err_q <= 1'b0;
            err_cnt_q  <= '0;
            locked_q   <= 1'b0;
            rel_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bin_vld_q  <= bin_vld_d;
            dir_q      <= dir_d;
            step_err_q <= step_err_d;
            err_cnt_q  <= err_cnt_d;
            locked_q   <= locked_d;
            rel_cnt_q  <= rel_cnt_d;
        end
    end

    assign bus.bin_out   = bin_q;
    assign bus.bin_valid = bin_vld_q;
    assign bus.dir       = dir_q;
    assign bus.step_err  = step_err_q;
    assign bus.err_count = err_cnt_q;
    assign bus.locked    = locked_q;

endmodule
